lpddr5x_port_arbiter: RTL
=========================

Name: lpddr5x_port_arbiter

Overview:
- Shares one LPDDR5x controller command/response port among NUM_REQ requesters (e.g. compute tiles, DMA, debug) using round-robin arbitration.
- Registers the granted command into a single output stage toward the controller.
- Tracks outstanding reads in an in-order tag FIFO and routes each read response back to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requester ports (2..16).
- ADDR_WIDTH, 32, command address width.
- DATA_WIDTH, 512, write/read data width.
- MAX_OUTSTANDING, 4, read-tag FIFO depth (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester command valid
- req_write_i  in  NUM_REQ  per-requester command type (1 = write)
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  flattened write data, same slicing
- req_ready_o  out  NUM_REQ  one-hot (or zero) acceptance
- rsp_valid_o  out  NUM_REQ  one-hot read-response valid
- rsp_rdata_o  out  DATA_WIDTH  read data, shared by all requesters
- mem_cmd_valid_o  out  1  command valid to controller
- mem_cmd_write_o  out  1  command type
- mem_cmd_addr_o  out  ADDR_WIDTH  command address
- mem_cmd_wdata_o  out  DATA_WIDTH  write data
- mem_cmd_ready_i  in  1  controller ready
- mem_rsp_valid_i  in  1  controller read-response valid
- mem_rsp_rdata_i  in  DATA_WIDTH  controller read data
- err_o  out  1  sticky error: response arrived with no outstanding read

Behaviour:
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, mem_cmd_valid_o=0, mem_cmd_write_o=0, mem_cmd_addr_o=0, mem_cmd_wdata_o=0, err_o=0. RR pointer=0, tag FIFO empty.
- Output stage
  - One register: mem_cmd_*.
  - stage_free = !mem_cmd_valid_o || mem_cmd_ready_i.
  - Contents are held stable while mem_cmd_valid_o && !mem_cmd_ready_i.
- Eligibility and grant
  - Requester i is eligible when req_valid_i[i] && (req_write_i[i] || !tag_full_eff).
  - tag_full_eff means the FIFO is full, counting a read in the output stage that is not yet pushed.
  - Grant (combinational) = first eligible index searching upward from the RR pointer, wrapping modulo NUM_REQ.
  - req_ready_o[g] = stage_free && eligible[g]. All other ready bits are 0.
- Accept (req_valid_i[g] && req_ready_o[g])
  - Next cycle the output stage holds requester g's command and mem_cmd_valid_o=1.
  - RR pointer <= (g+1) mod NUM_REQ.
  - No accept: pointer unchanged. Output stage clears to valid=0 when it drains.
- Throughput and latency
  - Back-to-back: 1 command per cycle when mem_cmd_ready_i stays high.
  - Request-to-controller latency is 1 cycle.
- Tag FIFO
  - Push the stage's requester ID when a read handshakes on the mem side (mem_cmd_valid_o && mem_cmd_ready_i && !mem_cmd_write_o).
  - Pop on mem_rsp_valid_i.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Response routing
  - One registered cycle: rsp_valid_o[head_id] <= 1 and rsp_rdata_o <= mem_rsp_rdata_i on the cycle after mem_rsp_valid_i.
  - rsp_rdata_o holds its last value otherwise. rsp_valid_o is a single-cycle pulse.
- Responses are in order; the controller returns reads in order.
- Writes never enter the FIFO and produce no response.
- mem_rsp_valid_i with the FIFO empty: err_o <= 1 (sticky until reset), no rsp_valid_o, no pointer change.
- Tag FIFO full:
  - Reads are masked from arbitration.
  - Writes remain eligible and may be granted in the masked requester's place.
  - The RR pointer still advances only on accept.
- Reset mid-operation (async): all state is cleared immediately. Outstanding reads are forgotten; later stray responses set err_o.

Decomposition:
- Package lpddr5x_arb_pkg: the MAX_REQ=16 constant, plus the req_id_t typedef (logic [3:0]) used for FIFO entries.
- Sub-module rr_arbiter: parameters N; ports req, ptr → one-hot gnt, gnt_idx, any. Purely combinational, reusable elsewhere.
- The tag FIFO stays inline in the top module.

Test Plan:
- All 4 requesters assert reads with mem_cmd_ready_i=1 and RR pointer 0 → grants in order 0,1,2,3. mem_cmd_valid_o stays high 4 consecutive cycles. Pointer returns to 0.
- Requester 2 writes addr 0x40, data 0xA5..; requester 2 then reads 0x40; controller returns 0xA5.. one cycle after the read → rsp_valid_o=4'b0100 for 1 cycle with rsp_rdata_o=0xA5... No response for the write.
- mem_cmd_ready_i=0 for 3 cycles with the stage holding requester 1's read of 0x100 → mem_cmd_* stable, all req_ready_o=0. Command issues on the cycle ready rises.
- Stall responses until 4 reads are outstanding, then requester 0 reads and requester 3 writes → requester 0 is blocked and requester 3's write is granted. After one response, requester 0 is granted next.
- Pulse mem_rsp_valid_i with the FIFO empty → err_o=1 stays high, rsp_valid_o=0. Deassert rst_ni mid-burst → all outputs return to reset values asynchronously.
- Same-cycle push and pop with 2 outstanding → count stays 2, and the response routes to the oldest requester ID.

Source files
------------

// File: rtl/lpddr5x_arb_pkg.sv
// Shared constants and types for the LPDDR5x port arbiter.
package lpddr5x_arb_pkg;

   localparam int MAX_REQ = 16;

   typedef logic [3:0] req_id_t;

endpackage

// File: rtl/lpddr5x_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   always_comb begin
      logic [IW:0] idx;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int off = 0; off < N; off++) begin
         idx = {1'b0, ptr} + (IW+1)'(off);
         if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
         if (!any && req[idx[IW-1:0]]) begin
            any                 = 1'b1;
            gnt[idx[IW-1:0]]    = 1'b1;
            gnt_idx             = idx[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/lpddr5x_port_arbiter.sv
// Round-robin share of one LPDDR5x controller port; read responses are routed
// back to their issuer through an in-order tag FIFO.
module lpddr5x_port_arbiter
   import lpddr5x_arb_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 512,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NUM_REQ-1:0]               req_valid_i,
   input  logic [NUM_REQ-1:0]               req_write_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
   output logic [NUM_REQ-1:0]               req_ready_o,
   output logic [NUM_REQ-1:0]               rsp_valid_o,
   output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
   output logic                             mem_cmd_valid_o,
   output logic                             mem_cmd_write_o,
   output logic [ADDR_WIDTH-1:0]            mem_cmd_addr_o,
   output logic [DATA_WIDTH-1:0]            mem_cmd_wdata_o,
   input  logic                             mem_cmd_ready_i,
   input  logic                             mem_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0]            mem_rsp_rdata_i,
   output logic                             err_o
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam logic [PW:0] MaxCnt = (PW+1)'(MAX_OUTSTANDING);

   logic                  cmd_valid_q, cmd_write_q;
   logic [ADDR_WIDTH-1:0] cmd_addr_q;
   logic [DATA_WIDTH-1:0] cmd_wdata_q;
   req_id_t               cmd_id_q;
   logic [IW-1:0]         rr_ptr_q, ptr_nxt;

   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [PW:0]           count_q;
   req_id_t               tag_mem [MAX_OUTSTANDING];
   logic [NUM_REQ-1:0]    rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic                  err_q;

   logic                  stage_free, tag_full_eff, accept, any_gnt, push, pop;
   logic [NUM_REQ-1:0]    eligible, gnt;
   logic [IW-1:0]         gnt_idx;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   assign stage_free   = !cmd_valid_q || mem_cmd_ready_i;
   // A read sitting in the stage already owns a FIFO slot even before it pushes.
   assign tag_full_eff = (count_q == MaxCnt) ||
                         ((count_q == MaxCnt - 1'b1) && cmd_valid_q && !cmd_write_q);
   assign eligible     = req_valid_i & (req_write_i | {NUM_REQ{!tag_full_eff}});

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req     (eligible),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any_gnt)
   );

   assign req_ready_o = stage_free ? gnt : '0;
   assign accept      = stage_free && any_gnt;
   assign ptr_nxt     = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   assign sel_write   = |(req_write_i & gnt);

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmd_valid_q <= 1'b0;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cmd_id_q    <= '0;
         rr_ptr_q    <= '0;
      end else if (accept) begin
         cmd_valid_q <= 1'b1;
         cmd_write_q <= sel_write;
         cmd_addr_q  <= sel_addr;
         cmd_wdata_q <= sel_wdata;
         cmd_id_q    <= req_id_t'(gnt_idx);
         rr_ptr_q    <= ptr_nxt;
      end else if (mem_cmd_ready_i) begin
         cmd_valid_q <= 1'b0;
      end
   end

   assign push = cmd_valid_q && mem_cmd_ready_i && !cmd_write_q;
   assign pop  = mem_rsp_valid_i && (count_q != '0);

   always_ff @(posedge clk_i) begin
      if (push) tag_mem[wr_ptr_q] <= cmd_id_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         rsp_valid_q <= pop ? (NUM_REQ'(1) << tag_mem[rd_ptr_q]) : '0;
         if (pop) rsp_rdata_q <= mem_rsp_rdata_i;
         if (mem_rsp_valid_i && (count_q == '0)) err_q <= 1'b1;
      end
   end

   assign mem_cmd_valid_o = cmd_valid_q;
   assign mem_cmd_write_o = cmd_write_q;
   assign mem_cmd_addr_o  = cmd_addr_q;
   assign mem_cmd_wdata_o = cmd_wdata_q;
   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_rdata_o     = rsp_rdata_q;
   assign err_o           = err_q;

endmodule
